instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: PC_RESET, 8'h00, PC value loaded on reset.
REQ-002 SHALL have port: clock  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high; sampled on posedge clock only.
REQ-004 SHALL have port: imem_addr  out  8  instruction memory address; equals pc.
REQ-005 SHALL have port: imem_req  out  1  fetch request; held high until imem_ack.
REQ-006 SHALL have port: imem_ack  in  1  memory has valid imem_data this cycle; ignored unless imem_req=1.
REQ-007 SHALL have port: imem_data  in  8  instruction word.
REQ-008 SHALL have port: instr_valid  out  1  instr/opcode/instr_pc hold a fetched instruction.
REQ-009 SHALL have port: instr_ready  in  1  decode/control stage accepts the instruction this cycle.
REQ-010 SHALL have port: instr  out  8  fetched word; [7:6] opcode, [5:4] rs, [3:2] rt, [1:0] rd/imm.
REQ-011 SHALL have port: opcode  out  2  instr[7:6]; drives the control unit's opcode input.
REQ-012 SHALL have port: instr_pc  out  8  address the held instruction was fetched from.
REQ-013 SHALL have port: branch_taken  in  1  single-cycle redirect request.
REQ-014 SHALL have port: branch_target  in  8  new pc; valid when branch_taken=1.

Function
REQ-015 SHALL implement three states: FETCH, HOLD, REDIRECT.
REQ-016 SHALL drive imem_req=1 only in FETCH with reset=0; imem_addr=pc combinationally in all states.
REQ-017 In FETCH, on imem_ack=1: instr<=imem_data, instr_pc<=pc, pc<=pc+1, instr_valid<=1, state<=HOLD.
REQ-018 In FETCH, with imem_ack=0: pc, imem_addr, imem_req SHALL stay stable; state remains FETCH.
REQ-019 In HOLD, instr_valid=1 and instr/opcode/instr_pc SHALL not change while instr_ready=0.
REQ-020 In HOLD, on instr_ready=1: instr_valid<=0, state<=FETCH; next imem_req rises the following cycle (min. 2 cycles per instruction).
REQ-021 pc increment SHALL be modulo 256: 8'hFF + 1 = 8'h00, no flag.
REQ-022 On branch_taken=1 in any state: pc<=branch_target, instr_valid<=0, state<=REDIRECT; this takes priority over imem_ack and instr_ready in the same cycle.
REQ-023 An imem_ack coinciding with branch_taken SHALL be discarded: instr/instr_pc unchanged, pc takes branch_target, not pc+1.
REQ-024 In REDIRECT, imem_req=0 for exactly one cycle, then state<=FETCH; a further branch_taken in REDIRECT reloads pc and stays in REDIRECT.
REQ-025 opcode SHALL equal instr[7:6] at all times, including while instr_valid=0.
REQ-026 instr_valid SHALL never be 1 in FETCH or REDIRECT.

Reset
REQ-027 On reset=1 at posedge: pc<=PC_RESET, state<=FETCH, instr<=8'h00, instr_pc<=8'h00, instr_valid<=0; reset overrides branch_taken, imem_ack, instr_ready.
REQ-028 Reset asserted mid-fetch (FETCH awaiting ack) or mid-HOLD SHALL drop any pending or held instruction; imem_req=0 while reset=1.
REQ-029 First fetch after reset deasserts SHALL present imem_addr=PC_RESET with imem_req=1 in the first cycle reset=0.

Verification
REQ-030 Reset then imem_ack same cycle as req, data 8'h4D at addr 00, instr_ready=1 -> instr=8'h4D, opcode=2'b01, instr_pc=00, next imem_addr=01.
REQ-031 imem_ack delayed 3 cycles -> imem_req and imem_addr constant for all 4 cycles; single capture, pc increments once.
REQ-032 instr_ready=0 for 5 cycles in HOLD -> instr_valid=1, instr/instr_pc unchanged, imem_req=0 throughout.
REQ-033 pc=8'hFF, ack with 8'hC0 -> instr_pc=FF, opcode=2'b11, next fetch address 8'h00.
REQ-034 branch_taken=1, branch_target=8'h20 in same cycle as imem_ack -> data discarded, instr_valid=0, one cycle imem_req=0, then imem_addr=20 with imem_req=1.
REQ-035 reset asserted in HOLD with instr_ready=1 -> instr_valid=0, instr=00, next fetch addr=PC_RESET; no acceptance of old instruction.

Source files
------------

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Single-outstanding fetch stage with hold/handshake and branch redirect.
// Revision : 1.0
// ============================================================================
module instruction_fetch #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] imem_addr,
    output logic       imem_req,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr,
    output logic [1:0] opcode,
    output logic [7:0] instr_pc,
    input  logic       branch_taken,
    input  logic [7:0] branch_target
);

    localparam logic [1:0] c_st_fetch    = 2'd0;
    localparam logic [1:0] c_st_hold     = 2'd1;
    localparam logic [1:0] c_st_redirect = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [7:0] r_pc;
    logic [7:0] w_pc_next;
    logic [7:0] r_instr;
    logic [7:0] w_instr_next;
    logic [7:0] r_instr_pc;
    logic [7:0] w_instr_pc_next;
    logic       r_valid;
    logic       w_valid_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_st_fetch;
            r_pc       <= PC_RESET;
            r_instr    <= 8'h00;
            r_instr_pc <= 8'h00;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_instr_pc <= w_instr_pc_next;
            r_valid    <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_instr_next    = r_instr;
        w_instr_pc_next = r_instr_pc;
        w_valid_next    = r_valid;
        // A redirect wins over a coincident ack or accept; the acked word is dropped.
        if (branch_taken) begin
            w_pc_next    = branch_target;
            w_valid_next = 1'b0;
            w_state_next = c_st_redirect;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (imem_ack) begin
                        w_instr_next    = imem_data;
                        w_instr_pc_next = r_pc;
                        w_pc_next       = r_pc + 8'd1;
                        w_valid_next    = 1'b1;
                        w_state_next    = c_st_hold;
                    end
                end
                c_st_hold: begin
                    if (instr_ready) begin
                        w_valid_next = 1'b0;
                        w_state_next = c_st_fetch;
                    end
                end
                c_st_redirect: begin
                    w_state_next = c_st_fetch;
                end
                default: begin
                    w_valid_next = 1'b0;
                    w_state_next = c_st_fetch;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign imem_req    = (r_state == c_st_fetch) && !reset;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign opcode      = r_instr[7:6];
    assign instr_pc    = r_instr_pc;

endmodule
`default_nettype wire
